// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and lane-geometry helpers for the systolic drain block.
package systolic_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;
  localparam int NUM_ROWS_W = 8;
  localparam int DEF_DATA_WIDTH = 4;
  function automatic int sum_width(input int dw);
    return dw * dw;
  endfunction
  function automatic int lane_lsb(input int lane, input int sw);
    return lane * sw;
  endfunction
  localparam int DEF_SUM_WIDTH = DEF_DATA_WIDTH * DEF_DATA_WIDTH;
endpackage

// File: rtl/skew_delay.sv
// skew_delay: fixed-depth register chain for one result lane; depth 0 degenerates to a wire.
module skew_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;
    assign o_q = i_d;
  end else begin : g_chain
    logic [WIDTH-1:0] r_q [DEPTH];
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      end else begin
        r_q[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
      end
    assign o_q = r_q[DEPTH-1];
  end
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: deskews systolic-array result lanes into aligned rows and buffers them behind a valid/ready port.
// Sticky overflow flag is built only when SYSTOLIC_DRAIN_OVF_EN is defined; ARRAY_SIZE must be at least 2.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 2,
  parameter int DATA_WIDTH = 4,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic                                         i_start,
  input  logic [NUM_ROWS_W-1:0]                        i_num_rows,
  input  logic [ARRAY_SIZE*sum_width(DATA_WIDTH)-1:0]  i_in_row,
  output logic [ARRAY_SIZE*sum_width(DATA_WIDTH)-1:0]  o_out_data,
  output logic                                         o_out_valid,
  input  logic                                         i_out_ready,
  output logic                                         o_out_last,
  output logic                                         o_busy,
  output logic                                         o_overflow
);
  localparam int SW = sum_width(DATA_WIDTH);
  localparam int RW = ARRAY_SIZE * SW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PIPE_LAT + ARRAY_SIZE + 1);
  localparam logic [CW-1:0] WAIT_END = CW'(PIPE_LAT - 1);
  localparam logic [CW-1:0] FILL_END = CW'(ARRAY_SIZE - 2);

  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt;
  logic [NUM_ROWS_W-1:0]   r_rows, r_num;
  logic [AW:0]             r_wp, r_rp;
  logic [RW:0]             r_mem [FIFO_DEPTH];
  logic [RW-1:0]           w_row;
  logic [AW-1:0]           w_wp_prev;
  logic w_start_ok, w_push, w_final, w_full, w_empty, w_pop, w_wr, w_drop;

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    skew_delay #(.DEPTH(ARRAY_SIZE - 1 - j), .WIDTH(SW)) u_skew (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_d    (i_in_row[lane_lsb(j, SW) +: SW]),
      .o_q    (w_row[lane_lsb(j, SW) +: SW])
    );
  end

  assign w_start_ok = i_start && r_state == S_IDLE && i_num_rows != '0;
  // r_cnt saturates once the deskew chains are full, so every later CAPTURE cycle pushes a row
  assign w_push     = r_state == S_CAPTURE && r_cnt == FILL_END;
  assign w_final    = r_rows == r_num - 1'b1;
  assign w_empty    = r_wp == r_rp;
  assign w_full     = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_pop      = !w_empty && i_out_ready;
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && !w_wr;
  assign w_wp_prev  = r_wp[AW-1:0] - 1'b1;

  assign o_out_valid = !w_empty;
  assign o_out_data  = w_empty ? '0 : r_mem[r_rp[AW-1:0]][RW-1:0];
  assign o_out_last  = !w_empty && r_mem[r_rp[AW-1:0]][RW];
  assign o_busy      = r_state != S_IDLE;

  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == S_IDLE    && w_start_ok)           ? S_WAIT    :
                 (r_state == S_WAIT    && r_cnt == WAIT_END)    ? S_CAPTURE :
                 (r_state == S_CAPTURE && w_push && w_final)    ? S_DRAIN   :
                 (r_state == S_DRAIN   && w_pop && o_out_last)  ? S_IDLE    : r_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rows  <= '0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start_ok) begin
        r_cnt  <= '0;
        r_rows <= '0;
        r_num  <= i_num_rows;
      end else if (r_state == S_WAIT) begin
        r_cnt <= (r_cnt == WAIT_END) ? '0 : r_cnt + 1'b1;
      end else if (r_state == S_CAPTURE) begin
        r_cnt  <= w_push ? r_cnt : r_cnt + 1'b1;
        r_rows <= w_push ? r_rows + 1'b1 : r_rows;
      end
    end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end

  // a dropped final row moves the last marker onto the newest stored row
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= {w_final, w_row};
    else if (w_drop && w_final) r_mem[w_wp_prev][RW] <= 1'b1;

`ifdef SYSTOLIC_DRAIN_OVF_EN
  logic r_ovf;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ovf <= 1'b0;
    else if (w_start_ok) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  assign o_overflow = r_ovf;
`else
  assign o_overflow = 1'b0;
`endif
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 The block SHALL take parameter ARRAY_SIZE, default 2, giving the number of array columns and the number of result lanes.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 4, giving the operand width; lane width SUM_WIDTH = DATA_WIDTH*DATA_WIDTH.
REQ-003 The block SHALL take parameter PIPE_LAT, default 2, giving the cycles from start to the column-0 result of row 0.
REQ-004 The block SHALL take parameter FIFO_DEPTH, default 4 (power of two), giving the number of result rows buffered.
REQ-005 clk  input  1  single clock, all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-007 start  input  1  one-cycle pulse marking the cycle the first activation row enters the array.
REQ-008 num_rows  input  8  number of result rows to collect; sampled with start.
REQ-009 in_row  input  ARRAY_SIZE*SUM_WIDTH  skewed array output; lane j at bits [j*SUM_WIDTH +: SUM_WIDTH].
REQ-010 out_data  output  ARRAY_SIZE*SUM_WIDTH  aligned result row, same lane packing.
REQ-011 out_valid / out_ready  output / input  1 each  valid-ready handshake; a transfer occurs when both are 1 at a rising edge.
REQ-012 out_last  output  1  marks the final row of a job, qualified by out_valid.
REQ-013 busy  output  1  high from the cycle after start until the last row transfers.
REQ-014 overflow  output  1  sticky; a row was dropped because the FIFO was full.

Function
REQ-015 States SHALL be IDLE, WAIT, CAPTURE and DRAIN.
REQ-016 IDLE->WAIT on start when num_rows != 0; start with num_rows == 0 SHALL be ignored.
REQ-017 start while not IDLE SHALL be ignored, with no effect on the current job.
REQ-018 WAIT SHALL count PIPE_LAT cycles, then go to CAPTURE.
REQ-019 Lane j of row r SHALL be sampled at edge t0+PIPE_LAT+r+j, where t0 is the start edge.
REQ-020 Deskew: lane j SHALL be delayed ARRAY_SIZE-1-j cycles so all lanes of row r align; the row SHALL be pushed at edge t0+PIPE_LAT+r+ARRAY_SIZE-1.
REQ-021 CAPTURE->DRAIN after num_rows pushes; DRAIN->IDLE when the FIFO is empty after the out_last transfer.
REQ-022 Capture SHALL never stall, because the array cannot be backpressured; a push to a full FIFO SHALL drop the row and set overflow.
REQ-023 A push and a pop in the same cycle on a full FIFO SHALL both succeed with no drop.
REQ-024 out_valid SHALL be 1 whenever the FIFO is non-empty; out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 out_last SHALL be 1 on the row pushed as row num_rows-1; if that row was dropped, out_last SHALL be 1 on the last stored row.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to tell full from empty.
REQ-027 Lane values SHALL pass unmodified (no arithmetic on data).

Reset
REQ-028 At reset: state IDLE, FIFO empty, counters 0, delay lines 0; out_valid, out_last, busy and overflow 0; out_data 0.
REQ-029 Reset mid-job SHALL discard all buffered rows, with no partial output after release.
REQ-030 overflow SHALL clear only on reset or on an accepted start.

Configuration
REQ-031 With SYSTOLIC_DRAIN_OVF_EN defined, overflow detection SHALL be as in REQ-022/REQ-030.
REQ-032 With SYSTOLIC_DRAIN_OVF_EN undefined, overflow SHALL be tied 0, the drop behaviour SHALL be unchanged, and no sticky flop SHALL exist.

Structure
REQ-033 A shared package systolic_pkg SHALL hold the state enum, the SUM_WIDTH derivation and the lane-slice width constants.
REQ-034 One sub-module, skew_delay (a parameterised-depth register chain per lane, depth 0 = wire), SHALL implement the deskew.

Verification
REQ-035 Defaults; start@t0, num_rows=2; lane0=5@t0+2, lane1=7@t0+3, lane0=9@t0+3, lane1=11@t0+4, out_ready=1 -> rows {7,5} then {11,9}, second with out_last, busy low after.
REQ-036 Same job with out_ready=0 until all rows are pushed -> out_valid held, data stable, rows in order once ready=1.
REQ-037 num_rows=6, out_ready=0 -> 4 rows stored, overflow=1, out_last on the 4th row.
REQ-038 FIFO full with out_ready=1 during a push -> no drop, overflow stays 0.
REQ-039 reset low during CAPTURE -> all outputs 0 immediately; a new job after release completes cleanly.
REQ-040 start during DRAIN, and start with num_rows=0 -> both ignored, state unchanged.
